// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/ready bus between the memory stage and data memory
interface mem_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     dmem_req;
  logic                     dmem_we;
  logic [ADDRESS_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]    dmem_wdata;
  logic [3:0]               dmem_be;
  logic                     dmem_ready;
  logic [DATA_WIDTH-1:0]    dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - E->M pipeline register, load/store lane steering and data-memory handshake
module mem_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write_e,
  input  logic [1:0]               res_src_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  input  logic                     flush_m,
  mem_stage_if.master              dmem,
  output logic                     stall_m,
  output logic                     reg_write_m,
  output logic [1:0]               res_src_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  output logic                     mem_fault_m
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     reg_write_q, mem_write_q;
  logic [1:0]               res_src_q;
  logic [2:0]               funct3_q;
  logic [DATA_WIDTH-1:0]    alu_q, wdata_q;
  logic [4:0]               rd_q;
  logic [ADDRESS_WIDTH-1:0] pc4_q;
  logic [DATA_WIDTH-1:0]    read_data_q;

  logic                     is_store, is_load, mem_op, aligned, funct_ok, fault, access;
  logic                     req;
  logic [1:0]               off;
  logic [3:0]               be;
  logic [DATA_WIDTH-1:0]    wdata, rshift, load_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      res_src_q   <= 2'b00;
      funct3_q    <= 3'b000;
      alu_q       <= '0;
      wdata_q     <= '0;
      rd_q        <= 5'd0;
      pc4_q       <= '0;
    end else if (!stall_m) begin
      if (flush_m) begin
        reg_write_q <= 1'b0;
        mem_write_q <= 1'b0;
        res_src_q   <= 2'b00;
        funct3_q    <= 3'b000;
        alu_q       <= '0;
        wdata_q     <= '0;
        rd_q        <= 5'd0;
        pc4_q       <= '0;
      end else begin
        reg_write_q <= reg_write_e;
        mem_write_q <= mem_write_e;
        res_src_q   <= res_src_e;
        funct3_q    <= funct3_e;
        alu_q       <= alu_result_e;
        wdata_q     <= write_data_e;
        rd_q        <= rd_e;
        pc4_q       <= pc_plus4_e;
      end
    end
  end

  // A store takes precedence if both store and load selects are set.
  assign is_store = mem_write_q;
  assign is_load  = !mem_write_q && (res_src_q == 2'b01);
  assign mem_op   = is_store || is_load;
  assign off      = alu_q[1:0];

  always_comb begin
    aligned = 1'b0;
    case (funct3_q[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign funct_ok = is_store ? !funct3_q[2] : !(funct3_q[2] && funct3_q[1]);
  assign fault    = mem_op && !(aligned && funct_ok);
  assign access   = mem_op && !fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access) state_d = dmem.dmem_ready ? DONE : BUSY;
      BUSY:    if (dmem.dmem_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req     = 1'b0;
    stall_m = 1'b0;
    case (state_q)
      IDLE: begin
        req     = access;
        stall_m = access;
      end
      BUSY: begin
        req     = 1'b1;
        stall_m = 1'b1;
      end
      default: ;
    endcase
  end

  // Lanes derive only from the held M register, so they stay stable while BUSY.
  always_comb begin
    be    = 4'b0000;
    wdata = wdata_q;
    if (is_store) begin
      case (funct3_q[1:0])
        2'b00:   wdata = {4{wdata_q[7:0]}};
        2'b01:   wdata = {2{wdata_q[15:0]}};
        default: wdata = wdata_q;
      endcase
    end
    if (access) begin
      if (is_store) begin
        case (funct3_q[1:0])
          2'b00:   be = 4'b0001 << off;
          2'b01:   be = 4'b0011 << {off[1], 1'b0};
          default: be = 4'b1111;
        endcase
      end else begin
        be = 4'b1111;
      end
    end
  end

  assign rshift = dmem.dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = dmem.dmem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  read_data_q <= '0;
    else if (req && dmem.dmem_ready && is_load)  read_data_q <= load_ext;
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = access && is_store;
  assign dmem.dmem_addr  = {alu_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign dmem.dmem_wdata = wdata;
  assign dmem.dmem_be    = be;

  assign reg_write_m  = reg_write_q && !stall_m && !fault;
  assign mem_fault_m  = fault;
  assign res_src_m    = res_src_q;
  assign alu_result_m = alu_q;
  assign read_data_m  = read_data_q;
  assign rd_m         = rd_q;
  assign pc_plus4_m   = pc4_q;

endmodule
